// File: rtl/dma_frame_ring_pkg.sv
// Shared types and the slot address helper for the frame-buffer ring scheduler.
package dma_ring_pkg;

   typedef enum logic [1:0] {
      Idle,
      Issue,
      Busy
   } ring_state_t;

   localparam int unsigned MaxAddrBits = 64;

   // Computed wide; callers truncate to their own address width.
   function automatic logic [MaxAddrBits-1:0] slot_addr(input logic [MaxAddrBits-1:0] base,
                                                        input logic [31:0] idx,
                                                        input int unsigned shift);
      return base + ({32'b0, idx} << shift);
   endfunction

endpackage

// File: rtl/dma_frame_ring_if.sv
// Bundles the writer, consumer and status signals of dma_frame_ring.
interface dma_frame_ring_if #(
   parameter int unsigned AddrBits = 32,
   parameter int unsigned NumSlots = 4
);
   localparam int unsigned IdxBits = $clog2(NumSlots);

   logic                enable;
   logic [AddrBits-1:0] base_addr;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [AddrBits-1:0] cfg_addr;
   logic                dma_done;
   logic                frm_valid;
   logic                frm_ready;
   logic [IdxBits-1:0]  frm_slot;
   logic [AddrBits-1:0] frm_addr;
   logic                rel_valid;
   logic                full;
   logic                rel_err;
   logic [31:0]         frames;

   // Ring side.
   modport master (
      input  enable, base_addr, cfg_ready, dma_done, frm_ready, rel_valid,
      output cfg_valid, cfg_addr, frm_valid, frm_slot, frm_addr, full, rel_err, frames
   );

   // Writer/consumer side.
   modport slave (
      output enable, base_addr, cfg_ready, dma_done, frm_ready, rel_valid,
      input  cfg_valid, cfg_addr, frm_valid, frm_slot, frm_addr, full, rel_err, frames
   );

endinterface

// File: rtl/dma_frame_ring_ptr.sv
// Wrapping ring pointer; the extra MSB distinguishes full from empty.
module ring_ptr #(
   parameter int unsigned Width = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [Width-1:0] ptr_o
);

   logic [Width-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) begin
         ptr_d = ptr_q + Width'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/dma_frame_ring.sv
// Frame-buffer ring scheduler: issues slot addresses to the DMA writer, publishes
// completed slots in order and stalls while every slot is filling or held.
module dma_frame_ring
   import dma_ring_pkg::*;
#(
   parameter int unsigned AddrBits  = 32,
   parameter int unsigned NumSlots  = 4,
   parameter int unsigned SlotBytes = 4096
) (
   input logic            clk,
   input logic            rst,
   dma_frame_ring_if.master bus
);

   localparam int unsigned IdxBits   = $clog2(NumSlots);
   localparam int unsigned PtrBits   = IdxBits + 1;
   localparam int unsigned SlotShift = $clog2(SlotBytes);

   ring_state_t         state_q, state_d;
   logic [AddrBits-1:0] base_q, base_d;
   logic [AddrBits-1:0] cfg_addr_q, cfg_addr_d;
   logic                cfg_valid_q, cfg_valid_d;
   logic                rel_err_q, rel_err_d;
   logic [31:0]         frames_q, frames_d;

   logic               fill_inc, hand_inc, free_inc;
   logic [PtrBits-1:0] fill_ptr, hand_ptr, free_ptr, hand_next;
   logic [PtrBits:0]   occ_raw, occ;
   logic               full, frm_valid, rel_accept;

   ring_ptr #(.Width(PtrBits)) u_fill_ptr (
      .clk   (clk),
      .rst   (rst),
      .inc_i (fill_inc),
      .ptr_o (fill_ptr)
   );

   ring_ptr #(.Width(PtrBits)) u_hand_ptr (
      .clk   (clk),
      .rst   (rst),
      .inc_i (hand_inc),
      .ptr_o (hand_ptr)
   );

   ring_ptr #(.Width(PtrBits)) u_free_ptr (
      .clk   (clk),
      .rst   (rst),
      .inc_i (free_inc),
      .ptr_o (free_ptr)
   );

   // The slot being written counts as occupied while the frame is in flight.
   always_comb begin
      occ_raw = {1'b0, fill_ptr - free_ptr} + (PtrBits + 1)'(state_q == Busy);
      occ     = (occ_raw > (PtrBits + 1)'(NumSlots)) ? (PtrBits + 1)'(NumSlots) : occ_raw;
      full    = (occ == (PtrBits + 1)'(NumSlots));
   end

   assign frm_valid = (hand_ptr != fill_ptr);
   assign hand_inc  = frm_valid && bus.frm_ready;
   assign hand_next = hand_ptr + PtrBits'(hand_inc);

   // Post-increment hand pointer lets a slot be taken and released in one cycle.
   assign rel_accept = bus.rel_valid && (free_ptr != hand_next);
   assign free_inc   = rel_accept;
   assign rel_err_d  = rel_err_q | (bus.rel_valid & ~rel_accept);

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_valid_d = cfg_valid_q;
      frames_d    = frames_q;
      fill_inc    = 1'b0;
      unique case (state_q)
         Idle: begin
            if (bus.enable && !full) begin
               state_d     = Issue;
               cfg_valid_d = 1'b1;
               // Base may only move while no slot is filled or held.
               if (fill_ptr == free_ptr) begin
                  base_d     = bus.base_addr;
                  cfg_addr_d = AddrBits'(slot_addr(MaxAddrBits'(bus.base_addr),
                                                   32'(fill_ptr[IdxBits-1:0]), SlotShift));
               end else begin
                  cfg_addr_d = AddrBits'(slot_addr(MaxAddrBits'(base_q),
                                                   32'(fill_ptr[IdxBits-1:0]), SlotShift));
               end
            end
         end
         Issue: begin
            if (bus.cfg_ready) begin
               state_d     = Busy;
               cfg_valid_d = 1'b0;
            end
         end
         Busy: begin
            if (bus.dma_done) begin
               state_d  = Idle;
               fill_inc = 1'b1;
               frames_d = frames_q + 32'd1;
            end
         end
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= Idle;
         base_q      <= '0;
         cfg_addr_q  <= '0;
         cfg_valid_q <= 1'b0;
         rel_err_q   <= 1'b0;
         frames_q    <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_valid_q <= cfg_valid_d;
         rel_err_q   <= rel_err_d;
         frames_q    <= frames_d;
      end
   end

   assign bus.cfg_valid = cfg_valid_q;
   assign bus.cfg_addr  = cfg_addr_q;
   assign bus.frm_valid = frm_valid;
   assign bus.frm_slot  = hand_ptr[IdxBits-1:0];
   assign bus.frm_addr  = AddrBits'(slot_addr(MaxAddrBits'(base_q),
                                              32'(hand_ptr[IdxBits-1:0]), SlotShift));
   assign bus.full      = full;
   assign bus.rel_err   = rel_err_q;
   assign bus.frames    = frames_q;

endmodule

// File: tb/tb_dma_frame_ring.sv
// Directed bench for dma_frame_ring: basic frame, wrap, full stall, enable drop,
// spurious release and mid-frame reset.
module tb_dma_frame_ring;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   dma_frame_ring_if #(.AddrBits(32), .NumSlots(4)) bus ();

   dma_frame_ring #(
      .AddrBits  (32),
      .NumSlots  (4),
      .SlotBytes (4096)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.enable    = 1'b0;
      bus.cfg_ready = 1'b0;
      bus.dma_done  = 1'b0;
      bus.frm_ready = 1'b0;
      bus.rel_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Waits for an offer, accepts it, then ends the frame a few cycles later.
   task automatic run_frame(input string tag, input logic [31:0] exp_addr);
      int n = 0;
      while (bus.cfg_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_cfg_valid"}, 64'(bus.cfg_valid), 64'd1);
      chk({tag, "_cfg_addr"}, 64'(bus.cfg_addr), 64'(exp_addr));
      bus.cfg_ready = 1'b1;
      tick();
      bus.cfg_ready = 1'b0;
      chk({tag, "_cfg_fall"}, 64'(bus.cfg_valid), 64'd0);
      tick();
      tick();
      bus.dma_done = 1'b1;
      tick();
      bus.dma_done = 1'b0;
      chk({tag, "_frm_valid"}, 64'(bus.frm_valid), 64'd1);
   endtask

   task automatic take_frame();
      bus.frm_ready = 1'b1;
      tick();
      bus.frm_ready = 1'b0;
   endtask

   task automatic release_slot();
      bus.rel_valid = 1'b1;
      tick();
      bus.rel_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] wrap_addr [4];
      int          seen;
      wrap_addr[0] = 32'h1000_1000;
      wrap_addr[1] = 32'h1000_2000;
      wrap_addr[2] = 32'h1000_3000;
      wrap_addr[3] = 32'h1000_0000;
      bus.base_addr = 32'h1000_0000;

      // Reset values and basic frame
      do_reset();
      chk("rst_cfg_valid", 64'(bus.cfg_valid), 64'd0);
      chk("rst_frm_valid", 64'(bus.frm_valid), 64'd0);
      chk("rst_full", 64'(bus.full), 64'd0);
      chk("rst_rel_err", 64'(bus.rel_err), 64'd0);
      chk("rst_frames", 64'(bus.frames), 64'd0);
      chk("rst_cfg_addr", 64'(bus.cfg_addr), 64'd0);
      chk("rst_frm_slot", 64'(bus.frm_slot), 64'd0);
      chk("rst_frm_addr", 64'(bus.frm_addr), 64'd0);
      bus.enable = 1'b1;
      tick();
      chk("issue_latency", 64'(bus.cfg_valid), 64'd1);
      run_frame("basic", 32'h1000_0000);
      chk("basic_frm_slot", 64'(bus.frm_slot), 64'd0);
      chk("basic_frm_addr", 64'(bus.frm_addr), 64'h1000_0000);
      chk("basic_frames", 64'(bus.frames), 64'd1);
      take_frame();
      chk("basic_frm_taken", 64'(bus.frm_valid), 64'd0);
      release_slot();
      chk("basic_rel_err", 64'(bus.rel_err), 64'd0);

      // Ring wrap: four more frames, the last lands back on slot 0
      for (int i = 0; i < 4; i++) begin
         run_frame("wrap", wrap_addr[i]);
         chk("wrap_frm_addr", 64'(bus.frm_addr), 64'(wrap_addr[i]));
         take_frame();
         release_slot();
      end
      chk("wrap_frames", 64'(bus.frames), 64'd5);
      chk("wrap_rel_err", 64'(bus.rel_err), 64'd0);

      // Full stall
      do_reset();
      bus.enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_frame("fill", 32'h1000_0000 + 32'(i) * 32'h1000);
         take_frame();
      end
      chk("full_set", 64'(bus.full), 64'd1);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.cfg_valid) seen++;
         tick();
      end
      chk("full_no_issue", 64'(seen), 64'd0);
      chk("full_held", 64'(bus.full), 64'd1);
      release_slot();
      chk("full_cleared", 64'(bus.full), 64'd0);
      tick();
      chk("full_reissue", 64'(bus.cfg_valid), 64'd1);
      chk("full_reissue_addr", 64'(bus.cfg_addr), 64'h1000_0000);

      // Enable drop during Busy
      do_reset();
      bus.enable = 1'b1;
      tick();
      bus.cfg_ready = 1'b1;
      tick();
      bus.cfg_ready = 1'b0;
      bus.enable    = 1'b0;
      tick();
      tick();
      bus.dma_done = 1'b1;
      tick();
      bus.dma_done = 1'b0;
      chk("en_frm_valid", 64'(bus.frm_valid), 64'd1);
      chk("en_frames", 64'(bus.frames), 64'd1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.cfg_valid) seen++;
         tick();
      end
      chk("en_no_issue", 64'(seen), 64'd0);
      bus.enable = 1'b1;
      tick();
      chk("en_resume", 64'(bus.cfg_valid), 64'd1);
      chk("en_resume_addr", 64'(bus.cfg_addr), 64'h1000_1000);

      // Spurious release, stray done, coincident done + release
      do_reset();
      release_slot();
      chk("spur_rel_err", 64'(bus.rel_err), 64'd1);
      chk("spur_frm_valid", 64'(bus.frm_valid), 64'd0);
      bus.dma_done = 1'b1;
      tick();
      bus.dma_done = 1'b0;
      chk("stray_done_frames", 64'(bus.frames), 64'd0);
      chk("stray_done_frm_valid", 64'(bus.frm_valid), 64'd0);
      bus.enable = 1'b1;
      run_frame("spur_a", 32'h1000_0000);
      take_frame();
      seen = 0;
      while (bus.cfg_valid !== 1'b1 && seen < 40) begin
         tick();
         seen++;
      end
      chk("coin_cfg_addr", 64'(bus.cfg_addr), 64'h1000_1000);
      bus.cfg_ready = 1'b1;
      tick();
      bus.cfg_ready = 1'b0;
      bus.enable    = 1'b0;
      tick();
      bus.dma_done  = 1'b1;
      bus.rel_valid = 1'b1;
      tick();
      bus.dma_done  = 1'b0;
      bus.rel_valid = 1'b0;
      chk("coin_frames", 64'(bus.frames), 64'd2);
      chk("coin_frm_slot", 64'(bus.frm_slot), 64'd1);
      chk("coin_frm_addr", 64'(bus.frm_addr), 64'h1000_1000);
      chk("coin_full", 64'(bus.full), 64'd0);
      chk("coin_rel_err_sticky", 64'(bus.rel_err), 64'd1);

      // Mid-frame reset with a new base
      do_reset();
      bus.enable = 1'b1;
      run_frame("pre_rst", 32'h1000_0000);
      while (bus.cfg_valid !== 1'b1 && seen < 80) begin
         tick();
         seen++;
      end
      bus.cfg_ready = 1'b1;
      tick();
      bus.cfg_ready = 1'b0;
      bus.base_addr = 32'h2000_0000;
      rst = 1'b1;
      tick();
      chk("mrst_cfg_valid", 64'(bus.cfg_valid), 64'd0);
      chk("mrst_frm_valid", 64'(bus.frm_valid), 64'd0);
      chk("mrst_frames", 64'(bus.frames), 64'd0);
      chk("mrst_full", 64'(bus.full), 64'd0);
      chk("mrst_cfg_addr", 64'(bus.cfg_addr), 64'd0);
      chk("mrst_frm_addr", 64'(bus.frm_addr), 64'd0);
      rst = 1'b0;
      tick();
      chk("mrst_new_cfg_valid", 64'(bus.cfg_valid), 64'd1);
      chk("mrst_new_cfg_addr", 64'(bus.cfg_addr), 64'h2000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
